// File: rtl/lcd_result_driver.sv
// HD44780 16x2 result display driver: power-up init, then renders a mnemonic
// and a signed 6-char decimal value for each start request from the CPU.
//
// state     | meaning
// INIT_WAIT | power-up settle, lcd_e held low
// INIT_CMD  | function set / display on / entry mode / clear
// IDLE      | waiting for start; busy low
// CONVERT   | 16-cycle double-dabble of the latched magnitude
// WRITE     | 12 byte transactions: line 1 mnemonic, line 2 value
module lcd_result_driver #(
    parameter int POWERUP_CYC = 750000,
    parameter int E_CYC       = 12,
    parameter int CMD_CYC     = 2000,
    parameter int CLEAR_CYC   = 82000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  opcode,
    input  logic [15:0] result,
    output logic        busy,
    output logic        done,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_e,
    output logic [7:0]  lcd_data
);
    localparam int CW0 = $clog2(POWERUP_CYC + CLEAR_CYC + CMD_CYC + E_CYC + 1);
    localparam int CW  = (CW0 < 5) ? 5 : CW0;

    typedef enum logic [2:0] {S_INIT_WAIT, S_INIT_CMD, S_IDLE, S_CONVERT, S_WRITE} state_t;
    typedef enum logic [1:0] {P_SETUP, P_EHI, P_WAIT} phase_t;

    state_t          state_q, state_d;
    phase_t          phase_q, phase_d;
    logic [CW-1:0]   cnt_q, cnt_d, wait_term;
    logic [3:0]      idx_q, idx_d;
    logic [2:0]      op_q, op_d;
    logic            sign_q, sign_d;
    logic [15:0]     bin_q, bin_d;
    logic [19:0]     bcd_q, bcd_d, bcd_t;
    logic            e_d, rs_d, done_d;
    logic [7:0]      data_d;

    function automatic logic [8:0] init_byte(input logic [3:0] i);
        case (i)
            4'd0:    return 9'h038;
            4'd1:    return 9'h00C;
            4'd2:    return 9'h006;
            default: return 9'h001;
        endcase
    endfunction

    function automatic logic [7:0] mnem_char(input logic [2:0] op, input logic [1:0] pos);
        logic [31:0] s;
        case (op)
            3'd0:    s = "LOAD";
            3'd1:    s = "ADD ";
            3'd2:    s = "ADDI";
            3'd3:    s = "SUB ";
            3'd4:    s = "SUBI";
            3'd5:    s = "MUL ";
            3'd6:    s = "CLR ";
            default: s = "DISP";
        endcase
        return s[31 - 8 * int'(pos) -: 8];
    endfunction

    // {rs, data} for write byte i: 0x80, mnemonic, 0xC0, sign, 5 digits MSD first
    function automatic logic [8:0] write_byte(input logic [3:0] i, input logic [2:0] op,
                                              input logic sgn, input logic [19:0] bcd);
        case (i)
            4'd0:                   return 9'h080;
            4'd1, 4'd2, 4'd3, 4'd4: return {1'b1, mnem_char(op, 2'(i - 4'd1))};
            4'd5:                   return 9'h0C0;
            4'd6:                   return {1'b1, sgn ? 8'h2D : 8'h2B};
            4'd7:                   return {5'b1_0011, bcd[19:16]};
            4'd8:                   return {5'b1_0011, bcd[15:12]};
            4'd9:                   return {5'b1_0011, bcd[11:8]};
            4'd10:                  return {5'b1_0011, bcd[7:4]};
            default:                return {5'b1_0011, bcd[3:0]};
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_INIT_WAIT;
            phase_q  <= P_SETUP;
            cnt_q    <= '0;
            idx_q    <= '0;
            op_q     <= '0;
            sign_q   <= 1'b0;
            bin_q    <= '0;
            bcd_q    <= '0;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            op_q     <= op_d;
            sign_q   <= sign_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            lcd_e    <= e_d;
            lcd_rs   <= rs_d;
            lcd_data <= data_d;
            done     <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        op_d      = op_q;
        sign_d    = sign_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        bcd_t     = bcd_q;
        rs_d      = lcd_rs;
        data_d    = lcd_data;
        done_d    = 1'b0;
        wait_term = (state_q == S_INIT_CMD && idx_q == 4'd3) ? CW'(CLEAR_CYC - 1) : CW'(CMD_CYC - 1);

        case (state_q)
            S_INIT_WAIT: begin
                if (cnt_q == CW'(POWERUP_CYC - 1)) begin
                    state_d          = S_INIT_CMD;
                    phase_d          = P_SETUP;
                    cnt_d            = '0;
                    idx_d            = '0;
                    {rs_d, data_d}   = init_byte(4'd0);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_INIT_CMD, S_WRITE: begin
                case (phase_q)
                    P_SETUP: begin
                        phase_d = P_EHI;
                        cnt_d   = '0;
                    end
                    P_EHI: begin
                        if (cnt_q == CW'(E_CYC - 1)) begin
                            phase_d = P_WAIT;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    default: begin
                        if (cnt_q == wait_term) begin
                            cnt_d = '0;
                            if ((state_q == S_INIT_CMD && idx_q == 4'd3) ||
                                (state_q == S_WRITE && idx_q == 4'd11)) begin
                                state_d = S_IDLE;
                                done_d  = (state_q == S_WRITE);
                            end else begin
                                idx_d   = idx_q + 4'd1;
                                phase_d = P_SETUP;
                                if (state_q == S_INIT_CMD)
                                    {rs_d, data_d} = init_byte(idx_q + 4'd1);
                                else
                                    {rs_d, data_d} = write_byte(idx_q + 4'd1, op_q, sign_q, bcd_q);
                            end
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                endcase
            end
            S_IDLE: begin
                if (start) begin
                    state_d = S_CONVERT;
                    cnt_d   = '0;
                    op_d    = opcode;
                    sign_d  = result[15];
                    bin_d   = result[15] ? (~result + 16'd1) : result;
                    bcd_d   = '0;
                end
            end
            default: begin
                // add-3 on any digit >= 5, then shift the next magnitude bit in
                for (int k = 0; k < 5; k++)
                    if (bcd_t[4*k +: 4] >= 4'd5)
                        bcd_t[4*k +: 4] = bcd_t[4*k +: 4] + 4'd3;
                bcd_d = {bcd_t[18:0], bin_q[15]};
                bin_d = {bin_q[14:0], 1'b0};
                if (cnt_q == CW'(15)) begin
                    state_d        = S_WRITE;
                    phase_d        = P_SETUP;
                    cnt_d          = '0;
                    idx_d          = '0;
                    {rs_d, data_d} = write_byte(4'd0, op_q, sign_q, bcd_d);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase

        e_d = (state_d == S_INIT_CMD || state_d == S_WRITE) && phase_d == P_EHI;
    end

    assign busy   = (state_q != S_IDLE);
    assign lcd_rw = 1'b0;
endmodule

// File: tb/tb_lcd_result_driver.sv
// Self-checking bench for lcd_result_driver: init sequence timing, display
// updates against a string/arithmetic model, start filtering and mid-write reset.
module tb_lcd_result_driver;
    localparam int PU = 20, EC = 2, CC = 5, CL = 10;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [2:0]  opcode = '0;
    logic [15:0] result = '0;
    logic        busy, done, lcd_rs, lcd_rw, lcd_e;
    logic [7:0]  lcd_data;

    lcd_result_driver #(.POWERUP_CYC(PU), .E_CYC(EC), .CMD_CYC(CC), .CLEAR_CYC(CL)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .result(result),
        .busy(busy), .done(done), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
        .lcd_data(lcd_data)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // bus monitor: capture {rs,data} on each lcd_e rise, confirm it holds through the pulse
    logic [8:0] cap_q[$];
    logic       mon_e = 1'b0;
    logic [8:0] mon_byte = '0;
    always @(negedge clk) begin
        if (rst) begin
            mon_e = 1'b0;
        end else begin
            if (lcd_e && !mon_e) begin
                mon_byte = {lcd_rs, lcd_data};
                cap_q.push_back(mon_byte);
            end
            if (!lcd_e && mon_e)
                chk("bus_hold", {23'd0, lcd_rs, lcd_data}, {23'd0, mon_byte});
            mon_e = lcd_e;
        end
    end

    // reference model for one display update
    logic [8:0] exp_q[$];
    string mn[8] = '{"LOAD", "ADD ", "ADDI", "SUB ", "SUBI", "MUL ", "CLR ", "DISP"};

    task automatic build_exp(input logic [2:0] op, input logic [15:0] val);
        int    v, mag, div;
        string m;
        exp_q.delete();
        exp_q.push_back(9'h080);
        m = mn[op];
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, m[i]});
        exp_q.push_back(9'h0C0);
        v   = int'($signed(val));
        mag = (v < 0) ? -v : v;
        exp_q.push_back({1'b1, (v < 0) ? 8'h2D : 8'h2B});
        div = 10000;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({1'b1, 8'(48 + (mag / div) % 10)});
            div = div / 10;
        end
    endtask

    task automatic check_reset_values(input string pfx);
        chk({pfx, "_busy"}, busy, 1);
        chk({pfx, "_done"}, done, 0);
        chk({pfx, "_e"}, lcd_e, 0);
        chk({pfx, "_rs"}, lcd_rs, 0);
        chk({pfx, "_rw"}, lcd_rw, 0);
        chk({pfx, "_data"}, lcd_data, 0);
    endtask

    task automatic power_up();
        int   rises[$], falls[$];
        int   busy_fall = -1, t = PU, w;
        logic pe = 1'b0;
        logic [8:0] init_exp[4] = '{9'h038, 9'h00C, 9'h006, 9'h001};
        cap_q.delete();
        @(negedge clk) rst = 1'b0;
        for (int c = 1; c <= 200 && busy_fall < 0; c++) begin
            @(negedge clk);
            if (lcd_e && !pe) rises.push_back(c);
            if (!lcd_e && pe) falls.push_back(c);
            if (!busy) busy_fall = c;
            pe = lcd_e;
        end
        chk("init_rises", rises.size(), 4);
        chk("init_falls", falls.size(), 4);
        for (int k = 0; k < 4; k++) begin
            w = (k == 3) ? CL : CC;
            if (k < rises.size()) chk($sformatf("init_rise%0d", k), rises[k], t + 1);
            if (k < falls.size()) chk($sformatf("init_fall%0d", k), falls[k], t + 1 + EC);
            // gap to next rise = wait cycles plus the next byte's setup cycle
            if (k < 3 && k + 1 < rises.size() && k < falls.size())
                chk($sformatf("init_gap%0d", k), rises[k+1] - falls[k], w + 1);
            t = t + 1 + EC + w;
        end
        if (falls.size() == 4) chk("init_clear_gap", busy_fall - falls[3], CL);
        chk("init_busy_fall", busy_fall, PU + 4 * (1 + EC) + 3 * CC + CL);
        chk("init_bytes", cap_q.size(), 4);
        for (int k = 0; k < 4 && k < cap_q.size(); k++)
            chk($sformatf("init_byte%0d", k), cap_q[k], init_exp[k]);
    endtask

    task automatic do_update(input logic [2:0] op, input logic [15:0] val, input bit repulse);
        int n = 0, guard = 0, done_cnt = 0;
        while (busy && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (busy) chk("idle_timeout", busy, 0);
        build_exp(op, val);
        cap_q.delete();
        start = 1'b1; opcode = op; result = val;
        @(negedge clk);
        start = 1'b0; opcode = 3'($urandom); result = 16'($urandom);
        while (busy && n < 1000) begin
            if (done) done_cnt++;
            n++;
            start = repulse && (n == 40);
            if (start) begin
                opcode = 3'd0;
                result = 16'd7;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("busy_cycles", n, 16 + 12 * (1 + EC + CC));
        chk("done_while_busy", done_cnt, 0);
        chk("done_pulse", done, 1);
        chk("byte_count", cap_q.size(), 12);
        for (int i = 0; i < 12 && i < cap_q.size(); i++)
            chk($sformatf("op%0d_byte%0d", op, i), cap_q[i], exp_q[i]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  ro;
        logic [15:0] rv;
        int          rises, busy_seen;
        logic        pe;

        repeat (3) @(negedge clk);
        check_reset_values("rst");
        power_up();

        do_update(3'd1, 16'd12345, 1'b0);
        do_update(3'd4, 16'h8000, 1'b0);
        do_update(3'd4, 16'hFFFF, 1'b0);
        do_update(3'd7, 16'h0000, 1'b0);
        repeat (6) begin
            ro = 3'($urandom);
            rv = 16'($urandom);
            do_update(ro, rv, 1'b0);
        end

        do_update(3'd3, 16'd42, 1'b1);
        cap_q.delete();
        busy_seen = 0;
        @(negedge clk);
        chk("done_clears", done, 0);
        repeat (40) begin
            if (busy) busy_seen++;
            @(negedge clk);
        end
        chk("no_second_update_busy", busy_seen, 0);
        chk("no_second_update_bytes", cap_q.size(), 0);

        // reset during the 5th write byte's enable pulse
        start = 1'b1; opcode = 3'd2; result = 16'd999;
        @(negedge clk);
        start = 1'b0;
        rises = 0;
        pe = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (lcd_e && !pe) rises++;
            pe = lcd_e;
            if (rises == 5 && lcd_e) break;
            @(negedge clk);
        end
        chk("rst_at_byte5", rises, 5);
        chk("rst_pre_e", lcd_e, 1);
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        repeat (3) @(negedge clk);
        power_up();
        do_update(3'd6, 16'hFF85, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
